acc_requant: RTL

- Output stage directly downstream of the 4-stage DSP multiply-accumulate unit in the new Versat datapath.
- Takes each finished 2*DATA_W signed accumulator value, adds a bias, rounds and arithmetically shifts it, applies optional ReLU, and saturates it to a signed OUT_W word for the feature-map write-back.
- Three-stage pipeline with valid/ready handshake and backpressure, plus a saturation event counter.

---
 rtl/acc_requant.sv | 110 +++++++++++
 1 files changed

// File: rtl/acc_requant.sv
// rtl/acc_requant.sv - bias, round, shift, activate and saturate stage behind the MAC unit
// Optional build macro ACC_REQUANT_LEAKY_EN selects leaky ReLU (slope 1/8) instead of plain ReLU.
module acc_requant #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic [2*DATA_W-1:0]   cfg_bias,
    input  logic                  cfg_relu,
    input  logic                  sat_clr,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           sat_cnt
);

    localparam int ACC_W = 2 * DATA_W;
    // Two guard bits: the sum of two full-scale operands plus the rounding term fits without wrap.
    localparam int SUM_W = ACC_W + 2;

    logic                    v1_q, v2_q, v3_q;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sh_q;
    logic                    advance;

    logic signed [SUM_W-1:0] round_c;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] act;
    logic                    over_hi;
    logic                    over_lo;
    logic [OUT_W-1:0]        sat_val;

    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign busy      = v1_q || v2_q || v3_q;

    always_comb begin
        round_c = '0;
        if (cfg_shift != '0) begin
            round_c = {{(SUM_W-1){1'b0}}, 1'b1} << (cfg_shift - SHIFT_W'(1));
        end
        sum_next = $signed({{2{in_data[ACC_W-1]}}, in_data})
                 + $signed({{2{cfg_bias[ACC_W-1]}}, cfg_bias})
                 + round_c;
    end

    always_comb begin
        act = sh_q;
        if (cfg_relu && sh_q[SUM_W-1]) begin
`ifdef ACC_REQUANT_LEAKY_EN
            act = sh_q >>> 3;
`else
            act = '0;
`endif
        end
        // Out of range whenever the bits above the output sign bit disagree with the sign.
        over_hi = !act[SUM_W-1] && (|act[SUM_W-2:OUT_W-1]);
        over_lo =  act[SUM_W-1] && !(&act[SUM_W-2:OUT_W-1]);
        if (over_hi) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (over_lo) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_val = act[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sum_q    <= '0;
            sh_q     <= '0;
            out_data <= '0;
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                sum_q <= sum_next;
            end
            if (v1_q) begin
                sh_q <= sum_q >>> cfg_shift;
            end
            if (v2_q) begin
                out_data <= sat_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (advance && v2_q && (over_hi || over_lo) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule
